// File: rtl/booth_pkg.sv
// Shared sizes and FSM encoding for the radix-2 Booth multiplier controller.
package booth_pkg;

  localparam int unsigned OPW   = 32;
  localparam int unsigned ITER  = 32;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/booth_mult_ctrl_step.sv
// One radix-2 Booth step: conditional add/subtract of M into A through a block
// carry-lookahead adder, then arithmetic right shift of {A,Q,Q_1}.
module booth_mult_ctrl_step
  import booth_pkg::*;
(
  input  logic [OPW-1:0] fh_a,
  input  logic [OPW-1:0] q,
  input  logic           ql,
  input  logic [OPW-1:0] m,
  output logic [OPW-1:0] fh_ao,
  output logic [OPW-1:0] qo,
  output logic [0:0]     qlo
);

  localparam int unsigned GW   = 4;
  localparam int unsigned NGRP = OPW / GW;

  logic [OPW-1:0]  operand;
  logic [OPW-1:0]  gen;
  logic [OPW-1:0]  prp;
  logic [OPW-1:0]  carry;
  logic [OPW-1:0]  sum;
  logic [OPW-1:0]  addsel;
  logic [NGRP-1:0] ggen;
  logic [NGRP-1:0] gprp;
  logic [NGRP-1:0] gcarry;

  always_comb begin
    // q[0]=1 only matters in the subtract case (10), so it doubles as invert and carry-in.
    operand = q[0] ? ~m : m;
    gen     = fh_a & operand;
    prp     = fh_a ^ operand;

    for (int gi = 0; gi < int'(NGRP); gi++) begin
      ggen[gi] = 1'b0;
      gprp[gi] = 1'b1;
      for (int b = 0; b < int'(GW); b++) begin
        ggen[gi] = gen[gi*GW + b] | (prp[gi*GW + b] & ggen[gi]);
        gprp[gi] = gprp[gi] & prp[gi*GW + b];
      end
    end

    // Group-level lookahead; the final carry-out is never formed.
    gcarry[0] = q[0];
    for (int gi = 0; gi < int'(NGRP) - 1; gi++) begin
      gcarry[gi+1] = ggen[gi] | (gprp[gi] & gcarry[gi]);
    end

    carry = '0;
    for (int gi = 0; gi < int'(NGRP); gi++) begin
      for (int b = 0; b < int'(GW); b++) begin
        if (b == 0) begin
          carry[gi*GW] = gcarry[gi];
        end else begin
          carry[gi*GW + b] = gen[gi*GW + b - 1] | (prp[gi*GW + b - 1] & carry[gi*GW + b - 1]);
        end
      end
    end

    sum    = prp ^ carry;
    addsel = (q[0] ^ ql) ? sum : fh_a;

    fh_ao  = {addsel[OPW-1], addsel[OPW-1:1]};
    qo     = {addsel[0], q[OPW-1:1]};
    qlo    = q[0];
  end

endmodule

// File: rtl/booth_mult_ctrl.sv
// Sequential radix-2 Booth multiplier: 32 iterations per product, one step per
// clock, with back-to-back accepts from the DONE state.
module booth_mult_ctrl
  import booth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] m,
  input  logic [31:0] q,
  output logic        busy,
  output logic        done,
  output logic [63:0] product,
  output logic        ovf
);

  state_e state_q, state_d;

  logic [OPW-1:0]   a_q;
  logic [OPW-1:0]   q_q;
  logic             ql_q;
  logic [OPW-1:0]   m_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             ovf_out_q;
  logic [63:0]      product_q;
  logic             done_q;

  logic [OPW-1:0]   a_nxt;
  logic [OPW-1:0]   q_nxt;
  logic [0:0]       ql_nxt;
  logic             accept;
  logic             last;

  assign accept = start && ((state_q == IDLE) || (state_q == DONE));
  assign last   = (state_q == RUN) && (cnt_q == CNT_W'(ITER - 1));

  booth_mult_ctrl_step u_step (
    .fh_a  (a_q),
    .q     (q_q),
    .ql    (ql_q),
    .m     (m_q),
    .fh_ao (a_nxt),
    .qo    (q_nxt),
    .qlo   (ql_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q == RUN);
    done    = done_q;
    product = product_q;
    ovf     = ovf_out_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      q_q       <= '0;
      ql_q      <= 1'b0;
      m_q       <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      ovf_out_q <= 1'b0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        m_q   <= m;
        a_q   <= '0;
        q_q   <= q;
        ql_q  <= 1'b0;
        cnt_q <= '0;
        ovf_q <= (m == 32'h8000_0000);
      end else if (state_q == RUN) begin
        a_q   <= a_nxt;
        q_q   <= q_nxt;
        ql_q  <= ql_nxt[0];
        cnt_q <= cnt_q + 1'b1;
        if (last) begin
          product_q <= {a_nxt, q_nxt};
          ovf_out_q <= ovf_q;
          done_q    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Directed checks of the Booth multiplier controller against hand-computed products.
module tb_booth_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] m;
  logic [31:0] q;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  booth_mult_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .m       (m),
    .q       (q),
    .busy    (busy),
    .done    (done),
    .product (product),
    .ovf     (ovf)
  );

  // Present operands for one edge, then scramble them so later changes are proven harmless.
  task automatic do_accept(input logic [31:0] mv, input logic [31:0] qv);
    m = mv;
    q = qv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    m = $urandom;
    q = $urandom;
  endtask

  // Counts edges until done (-1 on timeout) and cycles with busy high.
  task automatic wait_done(output int cyc, output int busy_cyc);
    busy_cyc = busy ? 1 : 0;
    cyc = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cyc = n;
        break;
      end
      if (busy) busy_cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    m = '0;
    q = '0;
    @(posedge clk);
    #1;
    start = 1'b1;
    m = 32'd3;
    q = 32'd5;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    checks++;
    if (product !== 64'h0) begin
      errors++; $display("FAIL reset_product: got %h want 0", product);
    end
  endtask

  task automatic test_basic();
    int cyc, bc;
    do_accept(32'd3, 32'd5);
    wait_done(cyc, bc);
    checks++;
    if (cyc != 32) begin errors++; $display("FAIL basic_latency: got %0d want 32", cyc); end
    checks++;
    if (bc != 32) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 32", bc); end
    checks++;
    if (product !== 64'h0000_0000_0000_000F) begin
      errors++; $display("FAIL basic_product: got %h want f", product);
    end
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b want 0", ovf); end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_after: got done=%b busy=%b want 0 0", done, busy);
    end
    checks++;
    if (product !== 64'hF) begin
      errors++; $display("FAIL basic_hold: got %h want f", product);
    end
  endtask

  task automatic test_signed();
    logic [31:0] tm [3];
    logic [31:0] tq [3];
    logic [63:0] tp [3];
    int cyc, bc;
    tm[0] = 32'hFFFF_FFF9; tq[0] = 32'h0000_0006; tp[0] = 64'hFFFF_FFFF_FFFF_FFD6;
    tm[1] = 32'h7FFF_FFFF; tq[1] = 32'h7FFF_FFFF; tp[1] = 64'h3FFF_FFFF_0000_0001;
    tm[2] = 32'hFFFF_FFFF; tq[2] = 32'h8000_0000; tp[2] = 64'h0000_0000_8000_0000;
    for (int i = 0; i < 3; i++) begin
      do_accept(tm[i], tq[i]);
      wait_done(cyc, bc);
      checks++;
      if (cyc != 32) begin
        errors++; $display("FAIL signed_latency[%0d]: got %0d want 32", i, cyc);
      end
      checks++;
      if (product !== tp[i]) begin
        errors++; $display("FAIL signed_product[%0d]: got %h want %h", i, product, tp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bc;
    do_accept(32'd3, 32'd5);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    m = 32'd9;
    q = 32'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc, bc);
    checks++;
    if (cyc != 21) begin errors++; $display("FAIL ignore_start_latency: got %0d want 21", cyc); end
    checks++;
    if (product !== 64'hF) begin
      errors++; $display("FAIL ignore_start_product: got %h want f", product);
    end
    m = 32'd2;
    q = 32'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_resume: got busy=%b done=%b want 1 0", busy, done);
    end
    checks++;
    if (product !== 64'hF) begin
      errors++; $display("FAIL b2b_hold: got %h want f", product);
    end
    wait_done(cyc, bc);
    checks++;
    if (cyc != 32) begin errors++; $display("FAIL b2b_latency: got %0d want 32", cyc); end
    checks++;
    if (product !== 64'h4) begin
      errors++; $display("FAIL b2b_product: got %h want 4", product);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc, bc;
    int seen;
    do_accept(32'd3, 32'd5);
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    if (done) seen++;
    checks++;
    if (seen != 0) begin errors++; $display("FAIL abort_done: got %0d pulses want 0", seen); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++;
    if (product !== 64'h0) begin
      errors++; $display("FAIL abort_product: got %h want 0", product);
    end
    do_accept(32'd4, 32'd4);
    wait_done(cyc, bc);
    checks++;
    if (cyc != 32) begin errors++; $display("FAIL abort_restart_latency: got %0d want 32", cyc); end
    checks++;
    if (product !== 64'h10) begin
      errors++; $display("FAIL abort_restart_product: got %h want 10", product);
    end
  endtask

  task automatic test_ovf();
    int cyc, bc;
    do_accept(32'h8000_0000, 32'd1);
    wait_done(cyc, bc);
    checks++;
    if (cyc != 32) begin errors++; $display("FAIL ovf_latency: got %0d want 32", cyc); end
    checks++;
    if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", ovf); end
    @(posedge clk);
    #1;
    do_accept(32'd2, 32'd3);
    checks++;
    if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_hold: got %b want 1", ovf); end
    wait_done(cyc, bc);
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", ovf); end
    checks++;
    if (product !== 64'h6) begin
      errors++; $display("FAIL ovf_next_product: got %h want 6", product);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_back_to_back();
    test_reset_mid_run();
    test_ovf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
